// File: rtl/esdi_cmd_sequencer.sv
// ESDI command sequencer: answers status/config requests locally, forwards other commands to software.
// Optional seek tracking (opcode 0 handled in hardware) is enabled by defining ESDI_SEEK_TRACK_EN.
module esdi_cmd_sequencer #(
  parameter int CFG_AW     = 3,
  parameter int SW_FIFO_AW = 2
) (
  input  logic              csr_aclk,
  input  logic              csr_aresetn,
  input  logic              enable,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [15:0]       cmd_data,
  input  logic              cmd_parity_err,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [15:0]       resp_data,
  output logic              done_valid,
  output logic              attn_req,
  input  logic [15:0]       status_word,
  input  logic              cfg_we,
  input  logic [CFG_AW-1:0] cfg_addr,
  input  logic [15:0]       cfg_wdata,
  output logic              sw_cmd_valid,
  input  logic              sw_cmd_ready,
  output logic [15:0]       sw_cmd_data,
  input  logic              sw_resp_valid,
  input  logic              sw_resp_none,
  input  logic [15:0]       sw_resp_data,
  output logic [11:0]       cur_cylinder
);

  localparam int CFG_DEPTH  = 2 ** CFG_AW;
  localparam int FIFO_DEPTH = 2 ** SW_FIFO_AW;
  localparam logic [SW_FIFO_AW:0] PTR_ONE = 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DECODE  = 3'd1,
    LOOKUP  = 3'd2,
    RESPOND = 3'd3,
    SW_WAIT = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [15:0]         cmd_q;
  logic                perr_q;
  logic [15:0]         cfg_mem  [CFG_DEPTH];
  logic [15:0]         fifo_mem [FIFO_DEPTH];
  logic [SW_FIFO_AW:0] wr_ptr, rd_ptr;
  logic                fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [3:0]          opcode;
  logic                cfg_mod_bad;
  logic                is_seek, seek_over, seek_upd;

  assign opcode      = cmd_q[15:12];
  assign cfg_mod_bad = |cmd_q[7:CFG_AW];

`ifdef ESDI_SEEK_TRACK_EN
  assign is_seek   = (opcode == 4'h0);
  assign seek_over = (cmd_q[11:0] > cfg_mem[0][11:0]);
`else
  assign is_seek   = 1'b0;
  assign seek_over = 1'b0;
`endif

  // Full when the low bits match but the wrap bits differ.
  assign fifo_empty   = (wr_ptr == rd_ptr);
  assign fifo_full    = (wr_ptr[SW_FIFO_AW] != rd_ptr[SW_FIFO_AW]) &&
                        (wr_ptr[SW_FIFO_AW-1:0] == rd_ptr[SW_FIFO_AW-1:0]);
  assign fifo_pop     = sw_cmd_ready && !fifo_empty;
  assign sw_cmd_valid = !fifo_empty;
  assign sw_cmd_data  = fifo_mem[rd_ptr[SW_FIFO_AW-1:0]];

  always_ff @(posedge csr_aclk or negedge csr_aresetn) begin
    if (!csr_aresetn) state_q <= IDLE;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (cmd_valid) state_d = DECODE;
        DECODE: begin
          if (perr_q)                state_d = IDLE;
          else if (opcode == 4'h2)   state_d = RESPOND;
          else if (opcode == 4'h3)   state_d = LOOKUP;
          else if (is_seek)          state_d = IDLE;
          else if (fifo_full)        state_d = IDLE;
          else                       state_d = SW_WAIT;
        end
        LOOKUP:  state_d = RESPOND;
        RESPOND: if (resp_ready) state_d = IDLE;
        SW_WAIT: if (sw_resp_valid) state_d = sw_resp_none ? IDLE : RESPOND;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cmd_ready  = enable && (state_q == IDLE);
    resp_valid = enable && (state_q == RESPOND);
    done_valid = 1'b0;
    attn_req   = 1'b0;
    fifo_push  = 1'b0;
    seek_upd   = 1'b0;
    if (enable && state_q == DECODE) begin
      if (perr_q) begin
        attn_req   = 1'b1;
        done_valid = 1'b1;
      end else if (opcode == 4'h2) begin
        attn_req   = 1'b0;
      end else if (opcode == 4'h3) begin
        attn_req   = cfg_mod_bad;
      end else if (is_seek) begin
        done_valid = 1'b1;
        attn_req   = seek_over;
        seek_upd   = !seek_over;
      end else if (fifo_full) begin
        attn_req   = 1'b1;
        done_valid = 1'b1;
      end else begin
        fifo_push  = 1'b1;
      end
    end
    if (enable && state_q == SW_WAIT && sw_resp_valid && sw_resp_none) done_valid = 1'b1;
  end

  always_ff @(posedge csr_aclk or negedge csr_aresetn) begin
    if (!csr_aresetn) begin
      cmd_q     <= '0;
      perr_q    <= 1'b0;
      resp_data <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        cmd_q  <= cmd_data;
        perr_q <= cmd_parity_err;
      end
      if (state_d == RESPOND) begin
        case (state_q)
          DECODE:  resp_data <= (cmd_q[7:0] == 8'h00) ? status_word : 16'h0000;
          LOOKUP:  resp_data <= cfg_mod_bad ? 16'h0000 : cfg_mem[cmd_q[CFG_AW-1:0]];
          SW_WAIT: resp_data <= sw_resp_data;
          default: resp_data <= resp_data;
        endcase
      end
      if (!enable) begin
        rd_ptr <= wr_ptr;
      end else begin
        if (fifo_push) wr_ptr <= wr_ptr + PTR_ONE;
        if (fifo_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // Storage arrays are not reset; the lookup read samples before this write lands.
  always_ff @(posedge csr_aclk) begin
    if (cfg_we)    cfg_mem[cfg_addr] <= cfg_wdata;
    if (fifo_push) fifo_mem[wr_ptr[SW_FIFO_AW-1:0]] <= cmd_q;
  end

`ifdef ESDI_SEEK_TRACK_EN
  always_ff @(posedge csr_aclk or negedge csr_aresetn) begin
    if (!csr_aresetn)  cur_cylinder <= '0;
    else if (seek_upd) cur_cylinder <= cmd_q[11:0];
  end
`else
  assign cur_cylinder = 12'h000;
`endif

endmodule

// File: tb/tb_esdi_cmd_sequencer.sv
// Directed bench for esdi_cmd_sequencer: a vector table for single commands plus hand sequences.
module tb_esdi_cmd_sequencer;

  logic        csr_aclk = 1'b0;
  logic        csr_aresetn = 1'b0;
  logic        enable = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_data = 16'h0000;
  logic        cmd_parity_err = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [15:0] resp_data;
  logic        done_valid;
  logic        attn_req;
  logic [15:0] status_word = 16'h0000;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_addr = 3'd0;
  logic [15:0] cfg_wdata = 16'h0000;
  logic        sw_cmd_valid;
  logic        sw_cmd_ready = 1'b0;
  logic [15:0] sw_cmd_data;
  logic        sw_resp_valid = 1'b0;
  logic        sw_resp_none = 1'b0;
  logic [15:0] sw_resp_data = 16'h0000;
  logic [11:0] cur_cylinder;

  int n_checks = 0;
  int n_fail = 0;

  always #5 csr_aclk = ~csr_aclk;

  esdi_cmd_sequencer #(.CFG_AW(3), .SW_FIFO_AW(2)) dut (
    .csr_aclk(csr_aclk), .csr_aresetn(csr_aresetn), .enable(enable),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .cmd_parity_err(cmd_parity_err), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .done_valid(done_valid), .attn_req(attn_req),
    .status_word(status_word), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .sw_cmd_valid(sw_cmd_valid), .sw_cmd_ready(sw_cmd_ready), .sw_cmd_data(sw_cmd_data),
    .sw_resp_valid(sw_resp_valid), .sw_resp_none(sw_resp_none), .sw_resp_data(sw_resp_data),
    .cur_cylinder(cur_cylinder)
  );

  typedef struct {
    logic [15:0] cmd;
    logic        perr;
    logic [15:0] status;
    int          exp_rv;    // cycle after accept in which resp_valid first shows, 0 = never
    logic [15:0] exp_data;
    int          exp_attn;
    int          exp_done;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge csr_aclk);
    #1;
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [15:0] d);
    step();
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    step();
    cfg_we = 1'b0;
  endtask

  // Returns just after the accept edge, i.e. inside the DECODE cycle.
  task automatic send_cmd(input logic [15:0] d, input logic p);
    bit got;
    got = 0;
    step();
    cmd_data = d; cmd_parity_err = p; cmd_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge csr_aclk);
      if (cmd_ready) begin
        @(posedge csr_aclk);
        #1;
        got = 1;
        break;
      end
    end
    cmd_valid = 1'b0; cmd_parity_err = 1'b0;
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: cmd %0h never accepted", d);
    end
  endtask

  task automatic watch(input int n, output int first_rv, output int attn_c, output int done_c,
                       output logic [15:0] rv_data, output bit stable);
    first_rv = 0; attn_c = 0; done_c = 0; rv_data = 16'h0000; stable = 1;
    for (int k = 1; k <= n; k++) begin
      @(negedge csr_aclk);
      if (attn_req)   attn_c++;
      if (done_valid) done_c++;
      if (resp_valid) begin
        if (first_rv == 0) begin
          first_rv = k;
          rv_data = resp_data;
        end else if (resp_data !== rv_data) stable = 0;
      end else if (first_rv != 0) stable = 0;
      if (k >= 2) status_word = ~status_word;
    end
  endtask

  task automatic ack();
    step();
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    @(negedge csr_aclk);
    chk("resp_valid_after_ack", resp_valid, 1'b0);
  endtask

  task automatic sw_reply(input logic none, input logic [15:0] d, output logic done_seen);
    step();
    sw_resp_valid = 1'b1; sw_resp_none = none; sw_resp_data = d;
    @(negedge csr_aclk);
    done_seen = done_valid;
    step();
    sw_resp_valid = 1'b0; sw_resp_none = 1'b0;
  endtask

  task automatic pop_chk(input logic [15:0] exp);
    @(negedge csr_aclk);
    chk("fifo_head_valid", sw_cmd_valid, 1'b1);
    chk("fifo_head_data", sw_cmd_data, exp);
    step();
    sw_cmd_ready = 1'b1;
    step();
    sw_cmd_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          rv, ac, dc;
    logic [15:0] rd;
    bit          st;
    logic        ds;

    vecs[0]  = '{16'h2000, 1'b0, 16'hA5C3, 2, 16'hA5C3, 0, 0};
    vecs[1]  = '{16'h2001, 1'b0, 16'hA5C3, 2, 16'h0000, 0, 0};
    vecs[2]  = '{16'h2080, 1'b0, 16'h1234, 2, 16'h0000, 0, 0};
    vecs[3]  = '{16'h2000, 1'b0, 16'h5A3C, 2, 16'h5A3C, 0, 0};
    vecs[4]  = '{16'h3003, 1'b0, 16'h0000, 3, 16'h0262, 0, 0};
    vecs[5]  = '{16'h3010, 1'b0, 16'h0000, 3, 16'h0000, 1, 0};
    vecs[6]  = '{16'h3000, 1'b0, 16'h0000, 3, 16'h03FF, 0, 0};
    vecs[7]  = '{16'h3007, 1'b0, 16'h0000, 3, 16'hBEEF, 0, 0};
    vecs[8]  = '{16'h3008, 1'b0, 16'h0000, 3, 16'h0000, 1, 0};
    vecs[9]  = '{16'h2000, 1'b1, 16'hA5C3, 0, 16'h0000, 1, 1};
    vecs[10] = '{16'h3003, 1'b1, 16'h0000, 0, 16'h0000, 1, 1};

    // Reset state, enable still low
    repeat (3) @(posedge csr_aclk);
    #1 csr_aresetn = 1'b1;
    @(negedge csr_aclk);
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_data", resp_data, 16'h0000);
    chk("rst_done", done_valid, 1'b0);
    chk("rst_attn", attn_req, 1'b0);
    chk("rst_sw_cmd_valid", sw_cmd_valid, 1'b0);
    chk("rst_cur_cyl", cur_cylinder, 12'h000);
    step();
    enable = 1'b1;
    @(negedge csr_aclk);
    chk("idle_cmd_ready", cmd_ready, 1'b1);

    cfg_write(3'd3, 16'h0262);
    cfg_write(3'd0, 16'h03FF);
    cfg_write(3'd7, 16'hBEEF);

    foreach (vecs[i]) begin
      status_word = vecs[i].status;
      send_cmd(vecs[i].cmd, vecs[i].perr);
      watch(7, rv, ac, dc, rd, st);
      chk($sformatf("v%0d_rv_cycle", i), rv, vecs[i].exp_rv);
      if (vecs[i].exp_rv != 0) begin
        chk($sformatf("v%0d_data", i), rd, vecs[i].exp_data);
        chk($sformatf("v%0d_stable", i), st, 1'b1);
      end
      chk($sformatf("v%0d_attn", i), ac, vecs[i].exp_attn);
      chk($sformatf("v%0d_done", i), dc, vecs[i].exp_done);
      chk($sformatf("v%0d_fifo_empty", i), sw_cmd_valid, 1'b0);
      if (rv != 0) ack();
    end

    // Read-first: write addr 3 while its lookup is in flight
    send_cmd(16'h3003, 1'b0);
    step();
    cfg_we = 1'b1; cfg_addr = 3'd3; cfg_wdata = 16'h1111;
    step();
    cfg_we = 1'b0;
    @(negedge csr_aclk);
    chk("rf_resp_valid", resp_valid, 1'b1);
    chk("rf_old_data", resp_data, 16'h0262);
    ack();
    send_cmd(16'h3003, 1'b0);
    watch(4, rv, ac, dc, rd, st);
    chk("rf_new_data", rd, 16'h1111);
    ack();

    // Fill the FIFO with four opcode-5 commands, each completed with no reply
    for (int i = 0; i < 4; i++) begin
      send_cmd(16'h5000 + 16'(i), 1'b0);
      watch(2, rv, ac, dc, rd, st);
      chk("fill_attn", ac, 0);
      chk("fill_done", dc, 0);
      chk("fill_sw_valid", sw_cmd_valid, 1'b1);
      sw_reply(1'b1, 16'h0000, ds);
      chk("fill_none_done", ds, 1'b1);
      @(negedge csr_aclk);
      chk("fill_no_resp", resp_valid, 1'b0);
    end
    send_cmd(16'h5004, 1'b0);
    watch(2, rv, ac, dc, rd, st);
    chk("full_attn", ac, 1);
    chk("full_done", dc, 1);
    chk("full_head", sw_cmd_data, 16'h5000);
    chk("full_idle", cmd_ready, 1'b1);
    // Push and pop together while full: pop wins, push reported as full
    send_cmd(16'h5005, 1'b0);
    sw_cmd_ready = 1'b1;
    @(negedge csr_aclk);
    chk("fullpop_attn", attn_req, 1'b1);
    chk("fullpop_done", done_valid, 1'b1);
    step();
    sw_cmd_ready = 1'b0;
    for (int i = 1; i < 4; i++) pop_chk(16'h5000 + 16'(i));
    @(negedge csr_aclk);
    chk("drained_empty", sw_cmd_valid, 1'b0);

    // Forwarded command with a software reply word
    send_cmd(16'h8000, 1'b0);
    watch(2, rv, ac, dc, rd, st);
    chk("fwd_no_resp_yet", rv, 0);
    pop_chk(16'h8000);
    sw_reply(1'b0, 16'h1234, ds);
    chk("fwd_reply_no_done", ds, 1'b0);
    @(negedge csr_aclk);
    chk("fwd_resp_valid", resp_valid, 1'b1);
    chk("fwd_resp_data", resp_data, 16'h1234);
    ack();
    sw_reply(1'b0, 16'hDEAD, ds);
    @(negedge csr_aclk);
    chk("idle_sw_resp_ignored", resp_valid, 1'b0);
    chk("idle_sw_resp_no_done", ds, 1'b0);

    // Abort while waiting on software
    send_cmd(16'h8001, 1'b0);
    watch(2, rv, ac, dc, rd, st);
    chk("abort_pre_fifo", sw_cmd_valid, 1'b1);
    step();
    enable = 1'b0;
    @(negedge csr_aclk);
    chk("abort_no_attn", attn_req, 1'b0);
    chk("abort_no_done", done_valid, 1'b0);
    chk("abort_ready_low", cmd_ready, 1'b0);
    step();
    enable = 1'b1;
    @(negedge csr_aclk);
    chk("abort_fifo_empty", sw_cmd_valid, 1'b0);
    chk("abort_idle", cmd_ready, 1'b1);
    sw_reply(1'b0, 16'h7777, ds);
    @(negedge csr_aclk);
    chk("abort_late_reply_ignored", resp_valid, 1'b0);

    // Abort with a reply pending
    status_word = 16'hC001;
    send_cmd(16'h2000, 1'b0);
    watch(2, rv, ac, dc, rd, st);
    chk("abort2_rv", rv, 2);
    step();
    enable = 1'b0;
    @(negedge csr_aclk);
    chk("abort2_resp_dropped", resp_valid, 1'b0);
    step();
    enable = 1'b1;
    @(negedge csr_aclk);
    chk("abort2_resp_stays_dropped", resp_valid, 1'b0);
    chk("abort2_idle", cmd_ready, 1'b1);

`ifdef ESDI_SEEK_TRACK_EN
    send_cmd(16'h0123, 1'b0);
    watch(2, rv, ac, dc, rd, st);
    chk("seek_done", dc, 1);
    chk("seek_attn", ac, 0);
    chk("seek_cyl", cur_cylinder, 12'h123);
    chk("seek_no_push", sw_cmd_valid, 1'b0);
    send_cmd(16'h0500, 1'b0);
    watch(2, rv, ac, dc, rd, st);
    chk("seek_over_attn", ac, 1);
    chk("seek_over_cyl", cur_cylinder, 12'h123);
    send_cmd(16'h03FF, 1'b0);
    watch(2, rv, ac, dc, rd, st);
    chk("seek_max_attn", ac, 0);
    chk("seek_max_cyl", cur_cylinder, 12'h3FF);
`else
    send_cmd(16'h0123, 1'b0);
    watch(2, rv, ac, dc, rd, st);
    chk("seek_fwd_done", dc, 0);
    chk("seek_fwd_cyl", cur_cylinder, 12'h000);
    sw_reply(1'b1, 16'h0000, ds);
    chk("seek_fwd_none_done", ds, 1'b1);
    pop_chk(16'h0123);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
